// File: rtl/openmips_pkg.sv
// Shared OpenMIPS constants and the EX/MEM forwarded-field bus.
package openmips_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int ALUOP_W_DEF = 8;

  localparam logic [DATA_W_DEF-1:0]  ZeroWord     = '0;
  localparam logic [REG_AW_DEF-1:0]  NOPRegAddr   = '0;
  localparam logic [ALUOP_W_DEF-1:0] EXE_NOP_OP   = '0;
  localparam logic                   WriteDisable = 1'b0;

  // Stall vector bit positions, ordered pc, if, id, ex, mem, wb.
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  typedef struct packed {
    logic                   valid;
    logic [REG_AW_DEF-1:0]  waddr;
    logic                   wreg;
    logic [DATA_W_DEF-1:0]  wdata;
    logic                   whilo;
    logic [DATA_W_DEF-1:0]  hi;
    logic [DATA_W_DEF-1:0]  lo;
    logic [ALUOP_W_DEF-1:0] aluop;
    logic [DATA_W_DEF-1:0]  mem_addr;
    logic [DATA_W_DEF-1:0]  reg2;
  } ex_mem_bus_t;

  // A bubble is the reset value: no GPR/HI/LO write, not valid.
  localparam ex_mem_bus_t BUBBLE = '{
    valid: 1'b0, waddr: NOPRegAddr, wreg: WriteDisable, wdata: ZeroWord,
    whilo: WriteDisable, hi: ZeroWord, lo: ZeroWord, aluop: EXE_NOP_OP,
    mem_addr: ZeroWord, reg2: ZeroWord
  };

endpackage

// File: rtl/ex_mem_pipe_sat_counter.sv
// Saturating up-counter with a synchronous load, async active-low reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with stall/flush handling and MADD/MSUB feedback.
// Optional bubble counter enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_pipe
  import openmips_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF,
  parameter int STALL_W = 6,
  parameter int EX_IDX  = STALL_EX,
  parameter int MEM_IDX = STALL_MEM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [REG_AW-1:0]   ex_waddr,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [ALUOP_W-1:0]  ex_aluop,
  input  logic [DATA_W-1:0]   ex_mem_addr,
  input  logic [DATA_W-1:0]   ex_reg2,
  input  logic [2*DATA_W-1:0] ex_hilo_temp,
  input  logic [1:0]          ex_cnt,
  output logic                mem_valid,
  output logic [REG_AW-1:0]   mem_waddr,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic [ALUOP_W-1:0]  mem_aluop,
  output logic [DATA_W-1:0]   mem_mem_addr,
  output logic [DATA_W-1:0]   mem_reg2,
  output logic [2*DATA_W-1:0] hilo_temp_o,
`ifdef EX_MEM_STALL_CNT_EN
  output logic [31:0]         bubble_cnt,
`endif
  output logic [1:0]          cnt_o
);

  ex_mem_bus_t bus_q;
  ex_mem_bus_t bus_d;
  logic        ex_only_stall;
  logic        bubble;

  assign bus_d = '{
    valid: ex_valid, waddr: ex_waddr, wreg: ex_wreg, wdata: ex_wdata,
    whilo: ex_whilo, hi: ex_hi, lo: ex_lo, aluop: ex_aluop,
    mem_addr: ex_mem_addr, reg2: ex_reg2
  };

  assign ex_only_stall = stall[EX_IDX] && !stall[MEM_IDX];
  assign bubble        = flush || ex_only_stall;

  // An EX-only stall bubbles MEM but keeps the MADD/MSUB state flowing back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_q       <= BUBBLE;
      hilo_temp_o <= '0;
      cnt_o       <= 2'b00;
    end else if (flush) begin
      bus_q       <= BUBBLE;
      hilo_temp_o <= '0;
      cnt_o       <= 2'b00;
    end else if (ex_only_stall) begin
      bus_q       <= BUBBLE;
      hilo_temp_o <= ex_hilo_temp;
      cnt_o       <= ex_cnt;
    end else if (!stall[EX_IDX]) begin
      bus_q       <= bus_d;
      hilo_temp_o <= '0;
      cnt_o       <= 2'b00;
    end
  end

  assign mem_valid    = bus_q.valid;
  assign mem_waddr    = bus_q.waddr;
  assign mem_wreg     = bus_q.wreg;
  assign mem_wdata    = bus_q.wdata;
  assign mem_whilo    = bus_q.whilo;
  assign mem_hi       = bus_q.hi;
  assign mem_lo       = bus_q.lo;
  assign mem_aluop    = bus_q.aluop;
  assign mem_mem_addr = bus_q.mem_addr;
  assign mem_reg2     = bus_q.reg2;

`ifdef EX_MEM_STALL_CNT_EN
  sat_counter #(.W(32)) u_bubble_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (bubble),
    .load     (1'b0),
    .load_val (32'h0),
    .count    (bubble_cnt)
  );
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed and randomized bench for ex_mem_pipe against a behavioural model.
module tb_ex_mem_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 8;
  localparam int SW = 6;

  logic          clk;
  logic          rst;
  logic [SW-1:0] stall;
  logic          flush;
  logic          ex_valid;
  logic [AW-1:0] ex_waddr;
  logic          ex_wreg;
  logic [DW-1:0] ex_wdata;
  logic          ex_whilo;
  logic [DW-1:0] ex_hi, ex_lo;
  logic [OW-1:0] ex_aluop;
  logic [DW-1:0] ex_mem_addr, ex_reg2;
  logic [2*DW-1:0] ex_hilo_temp;
  logic [1:0]    ex_cnt;
  logic          mem_valid;
  logic [AW-1:0] mem_waddr;
  logic          mem_wreg;
  logic [DW-1:0] mem_wdata;
  logic          mem_whilo;
  logic [DW-1:0] mem_hi, mem_lo;
  logic [OW-1:0] mem_aluop;
  logic [DW-1:0] mem_mem_addr, mem_reg2;
  logic [2*DW-1:0] hilo_temp_o;
  logic [1:0]    cnt_o;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0]   bubble_cnt;
`endif

  int total;
  int fails;

  // Expected MEM-side fields: index 0..9 follow the port order valid..reg2.
  logic [63:0] exp_f[10];
  logic [63:0] exp_hilo;
  logic [1:0]  exp_cnt;
  logic [31:0] exp_bub;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_waddr(ex_waddr), .ex_wreg(ex_wreg),
    .ex_wdata(ex_wdata), .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
    .mem_valid(mem_valid), .mem_waddr(mem_waddr), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2), .hilo_temp_o(hilo_temp_o),
`ifdef EX_MEM_STALL_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .cnt_o(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    check({step, ".mem_valid"},    64'(mem_valid),    exp_f[0]);
    check({step, ".mem_waddr"},    64'(mem_waddr),    exp_f[1]);
    check({step, ".mem_wreg"},     64'(mem_wreg),     exp_f[2]);
    check({step, ".mem_wdata"},    64'(mem_wdata),    exp_f[3]);
    check({step, ".mem_whilo"},    64'(mem_whilo),    exp_f[4]);
    check({step, ".mem_hi"},       64'(mem_hi),       exp_f[5]);
    check({step, ".mem_lo"},       64'(mem_lo),       exp_f[6]);
    check({step, ".mem_aluop"},    64'(mem_aluop),    exp_f[7]);
    check({step, ".mem_mem_addr"}, 64'(mem_mem_addr), exp_f[8]);
    check({step, ".mem_reg2"},     64'(mem_reg2),     exp_f[9]);
    check({step, ".hilo_temp_o"},  hilo_temp_o,       exp_hilo);
    check({step, ".cnt_o"},        64'(cnt_o),        64'(exp_cnt));
`ifdef EX_MEM_STALL_CNT_EN
    check({step, ".bubble_cnt"},   64'(bubble_cnt),   64'(exp_bub));
`endif
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 10; i++) exp_f[i] = '0;
    exp_hilo = '0;
    exp_cnt  = 2'b00;
    exp_bub  = '0;
  endfunction

  // Apply the pipeline-register rules to the model using the current inputs.
  function automatic void model_edge();
    logic ex_st, mem_st;
    ex_st  = stall[3];
    mem_st = stall[4];
    if (flush || (ex_st && !mem_st)) begin
      for (int i = 0; i < 10; i++) exp_f[i] = '0;
      exp_hilo = flush ? 64'h0 : ex_hilo_temp;
      exp_cnt  = flush ? 2'b00 : ex_cnt;
      if (exp_bub != 32'hFFFF_FFFF) exp_bub = exp_bub + 1;
    end else if (!ex_st) begin
      exp_f[0] = 64'(ex_valid);    exp_f[1] = 64'(ex_waddr);
      exp_f[2] = 64'(ex_wreg);     exp_f[3] = 64'(ex_wdata);
      exp_f[4] = 64'(ex_whilo);    exp_f[5] = 64'(ex_hi);
      exp_f[6] = 64'(ex_lo);       exp_f[7] = 64'(ex_aluop);
      exp_f[8] = 64'(ex_mem_addr); exp_f[9] = 64'(ex_reg2);
      exp_hilo = '0;
      exp_cnt  = 2'b00;
    end
  endfunction

  // Drive the edge after inputs have settled, then sample #1 past it.
  task automatic step(input string name);
    logic legal;
    legal = 1'b1;
    for (int i = 0; i < SW - 1; i++) if (stall[i + 1] && !stall[i]) legal = 1'b0;
    check({name, ".stall_monotonic"}, 64'(legal), 64'd1);
    if (rst) model_edge();
    @(posedge clk);
    #1;
    check_all(name);
    @(negedge clk);
  endtask

  task automatic randomize_ex();
    ex_valid     = 1'($urandom_range(0, 1));
    ex_waddr     = AW'($urandom);
    ex_wreg      = 1'($urandom_range(0, 1));
    ex_wdata     = $urandom;
    ex_whilo     = 1'($urandom_range(0, 1));
    ex_hi        = $urandom;
    ex_lo        = $urandom;
    ex_aluop     = OW'($urandom);
    ex_mem_addr  = $urandom;
    ex_reg2      = $urandom;
    ex_hilo_temp = {$urandom, $urandom};
    ex_cnt       = 2'($urandom_range(0, 3));
  endtask

  initial begin
    total = 0;
    fails = 0;
    rst = 1'b0;
    stall = '0;
    flush = 1'b0;
    randomize_ex();
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Normal flow
    randomize_ex();
    ex_valid = 1'b1; ex_waddr = 5'd8; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
    step("normal");

    // EX-only stall keeps MADD state moving
    stall = 6'b001111; ex_cnt = 2'b01; ex_hilo_temp = 64'h1234;
    step("ex_stall");

    // Capture then full hold for three cycles
    stall = 6'b000000; randomize_ex(); ex_wdata = 32'hA5A5A5A5; ex_valid = 1'b1;
    step("capture_a5");
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      randomize_ex();
      step("full_hold");
    end

    // Flush wins over an EX-only stall
    stall = 6'b001111; ex_cnt = 2'b10; flush = 1'b1;
    step("flush_over_stall");
    flush = 1'b0;

    // Carry cnt 2'b11 through unchanged
    ex_cnt = 2'b11; ex_hilo_temp = 64'hFFFF_0000_1111_2222;
    step("cnt_11");

    // Async reset asserted mid-cycle with nonzero outputs
    stall = 6'b000000; randomize_ex(); ex_valid = 1'b1; ex_waddr = 5'd31;
    step("pre_reset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);

    // Release reset during a full stall: first edge holds the reset state
    stall = 6'b011111; randomize_ex();
    rst = 1'b1;
    step("release_mid_stall");

    // Randomized legal stall vectors and occasional flushes
    for (int n = 0; n < 300; n++) begin
      randomize_ex();
      stall = SW'((1 << $urandom_range(0, SW)) - 1);
      flush = ($urandom_range(0, 7) == 0);
      step("random");
    end
    flush = 1'b0;
    stall = '0;

`ifdef EX_MEM_STALL_CNT_EN
    // Four EX-only stalls then one flush add five bubbles
    begin
      logic [31:0] base;
      base = exp_bub;
      stall = 6'b001111;
      for (int i = 0; i < 4; i++) step("cnt_stall");
      stall = 6'b000000; flush = 1'b1;
      step("cnt_flush");
      flush = 1'b0;
      check("bubble_delta", 64'(bubble_cnt - base), 64'd5);
    end
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Parametrised EX/MEM pipeline register, successor to the fixed-width write-back-only register. Carries the register write-back, HI/LO write, load/store fields, a valid bit and multi-cycle MADD/MSUB state from EX to MEM. Responds to the central stall vector and flush from the control unit. Sits between the ex and mem stages in the OpenMIPS core.

Parameters:
DATA_W, 32, GPR/HI/LO/data width
REG_AW, 5, register-file address width
ALUOP_W, 8, ALU opcode width
STALL_W, 6, stall vector width (pc, if, id, ex, mem, wb)
EX_IDX, 3, stall bit for the EX stage
MEM_IDX, 4, stall bit for the MEM stage

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
stall  in  STALL_W  per-stage stall from ctrl
flush  in  1  exception flush; kills the in-flight instruction
ex_valid  in  1  EX holds a real instruction
ex_waddr  in  REG_AW  destination GPR
ex_wreg  in  1  GPR write enable
ex_wdata  in  DATA_W  GPR write data
ex_whilo  in  1  HI/LO write enable
ex_hi, ex_lo  in  DATA_W each  HI/LO write data
ex_aluop  in  ALUOP_W  op, for MEM load/store decode
ex_mem_addr  in  DATA_W  effective address
ex_reg2  in  DATA_W  store data
ex_hilo_temp  in  2*DATA_W  MADD/MSUB partial product
ex_cnt  in  2  MADD/MSUB cycle count
mem_valid, mem_waddr, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2  out  widths as inputs  registered EX fields
hilo_temp_o  out  2*DATA_W  partial product fed back to EX
cnt_o  out  2  cycle count fed back to EX

Behaviour:
- Reset (rst=0, async): every output 0. mem_waddr = NOPRegAddr, mem_aluop = EXE_NOP_OP, mem_valid = 0.
- One-cycle latency. Priority per clk edge, highest first:
  1. flush=1: bubble. All mem_* = reset values, hilo_temp_o = 0, cnt_o = 0.
  2. stall[EX_IDX]=1 and stall[MEM_IDX]=0: bubble into MEM (mem_* = reset values). hilo_temp_o <= ex_hilo_temp; cnt_o <= ex_cnt (MADD accumulation continues across the stall).
  3. stall[EX_IDX]=0: capture all ex_* into mem_*. mem_valid <= ex_valid; hilo_temp_o <= 0; cnt_o <= 0.
  4. Otherwise (both stalled): hold every output unchanged.
- Bubble definition: mem_wreg = 0, mem_whilo = 0, mem_valid = 0, so no architectural side effect.
- stall[MEM_IDX]=1 with stall[EX_IDX]=0 is illegal, because ctrl guarantees monotonic stall. Required response: capture per rule 3. The bench asserts this never happens.
- Reset deasserting mid-stall: the first edge after release evaluates the rules normally from the reset state.
- cnt_o is carried, not incremented, here. Values 2'b00..2'b10 only; 2'b11 is passed through unchanged.

Optional Feature:
Macro EX_MEM_STALL_CNT_EN.
- Defined: adds output bubble_cnt (32 bits). It increments on every edge where rule 1 or 2 inserts a bubble, saturates at 32'hFFFF_FFFF, and resets to 0.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package openmips_pkg holds:
  - constants ZeroWord, NOPRegAddr, EXE_NOP_OP, WriteDisable;
  - stall index constants;
  - typedef ex_mem_bus_t, a packed struct of all forwarded fields, so the bubble is a single assignment.
- One sub-module, sat_counter (parametrised width), used only under EX_MEM_STALL_CNT_EN.

Test Plan:
- Async reset: pull rst=0 mid-cycle with outputs nonzero -> all outputs 0 immediately, before the next clk edge; mem_waddr=0.
- Normal flow: ex_waddr=5'd8, ex_wreg=1, ex_wdata=32'hDEADBEEF, stall=0 -> next edge mem_* match; mem_valid=1; cnt_o=0.
- EX-only stall: stall=6'b001111, ex_cnt=2'b01, ex_hilo_temp=64'h1234 -> mem_wreg=0, mem_valid=0, cnt_o=2'b01, hilo_temp_o=64'h1234.
- Full hold: capture wdata=32'hA5A5A5A5, then stall=6'b011111 for 3 cycles -> mem_wdata stays 32'hA5A5A5A5 and cnt_o is unchanged.
- Flush over stall: flush=1 with stall=6'b001111 and ex_cnt=2'b10 -> bubble, cnt_o=0, hilo_temp_o=0.
- With EX_MEM_STALL_CNT_EN: 4 EX-only stall cycles then 1 flush -> bubble_cnt=5; preload 32'hFFFF_FFFF, then one bubble -> bubble_cnt stays 32'hFFFF_FFFF.
